// File: rtl/aq_axils_arb2.sv
`default_nettype none
// ============================================================================
// Module   : aq_axils_arb2
// Brief    : Round-robin arbiter issuing two cs/ack requesters onto one
//            AXI4-Lite master port, one transaction at a time.
// Revision : 1.0
// ============================================================================
module aq_axils_arb2 #(
  parameter int TIMEOUT_CYC = 1023
) (
  input  logic        ACLK,
  input  logic        ARESETN,
  input  logic        REQ0_CS,
  input  logic        REQ0_RNW,
  input  logic [31:0] REQ0_ADDR,
  input  logic [3:0]  REQ0_BE,
  input  logic [31:0] REQ0_WDATA,
  output logic        REQ0_ACK,
  output logic [31:0] REQ0_RDATA,
  output logic        REQ0_ERR,
  input  logic        REQ1_CS,
  input  logic        REQ1_RNW,
  input  logic [31:0] REQ1_ADDR,
  input  logic [3:0]  REQ1_BE,
  input  logic [31:0] REQ1_WDATA,
  output logic        REQ1_ACK,
  output logic [31:0] REQ1_RDATA,
  output logic        REQ1_ERR,
  output logic [31:0] M_AXI_AWADDR,
  output logic        M_AXI_AWVALID,
  input  logic        M_AXI_AWREADY,
  output logic [3:0]  M_AXI_AWCACHE,
  output logic [2:0]  M_AXI_AWPROT,
  output logic [31:0] M_AXI_WDATA,
  output logic [3:0]  M_AXI_WSTRB,
  output logic        M_AXI_WVALID,
  input  logic        M_AXI_WREADY,
  input  logic        M_AXI_BVALID,
  input  logic [1:0]  M_AXI_BRESP,
  output logic        M_AXI_BREADY,
  output logic [31:0] M_AXI_ARADDR,
  output logic        M_AXI_ARVALID,
  input  logic        M_AXI_ARREADY,
  output logic [3:0]  M_AXI_ARCACHE,
  output logic [2:0]  M_AXI_ARPROT,
  input  logic [31:0] M_AXI_RDATA,
  input  logic [1:0]  M_AXI_RRESP,
  input  logic        M_AXI_RVALID,
  output logic        M_AXI_RREADY
);

  localparam int CW = (TIMEOUT_CYC < 2) ? 1 : $clog2(TIMEOUT_CYC + 1);
  localparam logic [CW-1:0] TO_VAL = CW'(TIMEOUT_CYC);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_WADDR = 3'd1,
    S_WRESP = 3'd2,
    S_RADDR = 3'd3,
    S_RDATA = 3'd4,
    S_DONE  = 3'd5
  } state_t;

  state_t         state_q, state_d;
  logic           gnt_q, gnt_d;
  logic           last_q, last_d;
  logic           rnw_q, rnw_d;
  logic [31:0]    addr_q, addr_d;
  logic [3:0]     be_q, be_d;
  logic [31:0]    wdata_q, wdata_d;
  logic           awdone_q, awdone_d;
  logic           wdone_q, wdone_d;
  logic           err_q, err_d;
  logic [31:0]    rdata_q, rdata_d;
  logic [CW-1:0]  cnt_q, cnt_d;

  logic w_phase;
  logic w_to;
  logic w_pick1;
  logic w_awvalid, w_wvalid, w_bready, w_arvalid, w_rready;

  assign w_phase = (state_q == S_WADDR) || (state_q == S_WRESP) ||
                   (state_q == S_RADDR) || (state_q == S_RDATA);
  assign w_to    = (TIMEOUT_CYC != 0) && w_phase && (cnt_q == TO_VAL);
  // Requester 1 wins only when alone or when requester 0 was served last.
  assign w_pick1 = REQ1_CS && (!REQ0_CS || !last_q);

  assign w_awvalid = (state_q == S_WADDR) && !awdone_q && !w_to;
  assign w_wvalid  = (state_q == S_WADDR) && !wdone_q  && !w_to;
  assign w_bready  = (state_q == S_WRESP) && !w_to;
  assign w_arvalid = (state_q == S_RADDR) && !w_to;
  assign w_rready  = (state_q == S_RDATA) && !w_to;

  always_comb begin
    state_d  = state_q;
    gnt_d    = gnt_q;
    last_d   = last_q;
    rnw_d    = rnw_q;
    addr_d   = addr_q;
    be_d     = be_q;
    wdata_d  = wdata_q;
    awdone_d = awdone_q;
    wdone_d  = wdone_q;
    err_d    = err_q;
    rdata_d  = rdata_q;
    cnt_d    = cnt_q;

    case (state_q)
      S_IDLE: begin
        if (REQ0_CS || REQ1_CS) begin
          gnt_d    = w_pick1;
          last_d   = w_pick1;
          rnw_d    = w_pick1 ? REQ1_RNW   : REQ0_RNW;
          addr_d   = w_pick1 ? REQ1_ADDR  : REQ0_ADDR;
          be_d     = w_pick1 ? REQ1_BE    : REQ0_BE;
          wdata_d  = w_pick1 ? REQ1_WDATA : REQ0_WDATA;
          awdone_d = 1'b0;
          wdone_d  = 1'b0;
          err_d    = 1'b0;
          rdata_d  = '0;
          state_d  = rnw_d ? S_RADDR : S_WADDR;
        end
      end
      S_WADDR: begin
        awdone_d = awdone_q || (w_awvalid && M_AXI_AWREADY);
        wdone_d  = wdone_q  || (w_wvalid  && M_AXI_WREADY);
        if (awdone_d && wdone_d) state_d = S_WRESP;
      end
      S_WRESP: begin
        if (M_AXI_BVALID) begin
          err_d   = (M_AXI_BRESP != 2'b00);
          state_d = S_DONE;
        end
      end
      S_RADDR: begin
        if (M_AXI_ARREADY) state_d = S_RDATA;
      end
      S_RDATA: begin
        if (M_AXI_RVALID) begin
          rdata_d = M_AXI_RDATA;
          err_d   = (M_AXI_RRESP != 2'b00);
          state_d = S_DONE;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // Debug escape: abandon a stuck phase without completing the handshake.
    if (w_to) begin
      state_d = S_DONE;
      err_d   = 1'b1;
      rdata_d = '0;
    end

    if (state_d != state_q) cnt_d = '0;
    else if (w_phase && (cnt_q != {CW{1'b1}})) cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      state_q  <= S_IDLE;
      gnt_q    <= 1'b0;
      last_q   <= 1'b1;
      rnw_q    <= 1'b0;
      addr_q   <= '0;
      be_q     <= '0;
      wdata_q  <= '0;
      awdone_q <= 1'b0;
      wdone_q  <= 1'b0;
      err_q    <= 1'b0;
      rdata_q  <= '0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      gnt_q    <= gnt_d;
      last_q   <= last_d;
      rnw_q    <= rnw_d;
      addr_q   <= addr_d;
      be_q     <= be_d;
      wdata_q  <= wdata_d;
      awdone_q <= awdone_d;
      wdone_q  <= wdone_d;
      err_q    <= err_d;
      rdata_q  <= rdata_d;
      cnt_q    <= cnt_d;
    end
  end

  assign M_AXI_AWADDR  = addr_q;
  assign M_AXI_AWVALID = w_awvalid;
  assign M_AXI_AWCACHE = 4'b0011;
  assign M_AXI_AWPROT  = 3'b000;
  assign M_AXI_WDATA   = wdata_q;
  assign M_AXI_WSTRB   = be_q;
  assign M_AXI_WVALID  = w_wvalid;
  assign M_AXI_BREADY  = w_bready;
  assign M_AXI_ARADDR  = addr_q;
  assign M_AXI_ARVALID = w_arvalid;
  assign M_AXI_ARCACHE = 4'b0011;
  assign M_AXI_ARPROT  = 3'b000;
  assign M_AXI_RREADY  = w_rready;

  assign REQ0_ACK   = (state_q == S_DONE) && !gnt_q;
  assign REQ1_ACK   = (state_q == S_DONE) &&  gnt_q;
  assign REQ0_ERR   = REQ0_ACK && err_q;
  assign REQ1_ERR   = REQ1_ACK && err_q;
  assign REQ0_RDATA = (REQ0_ACK && rnw_q) ? rdata_q : '0;
  assign REQ1_RDATA = (REQ1_ACK && rnw_q) ? rdata_q : '0;

endmodule
`default_nettype wire

// File: tb/tb_aq_axils_arb2.sv
`default_nettype none
// ============================================================================
// Module   : tb_aq_axils_arb2
// Brief    : Scoreboard bench for aq_axils_arb2 with a 4-register AXI-Lite
//            slave model having configurable ready delays and responses.
// Revision : 1.0
// ============================================================================
module tb_aq_axils_arb2;

  logic        ACLK, ARESETN;
  logic        REQ0_CS, REQ0_RNW, REQ1_CS, REQ1_RNW;
  logic [31:0] REQ0_ADDR, REQ0_WDATA, REQ1_ADDR, REQ1_WDATA;
  logic [3:0]  REQ0_BE, REQ1_BE;
  logic        REQ0_ACK, REQ0_ERR, REQ1_ACK, REQ1_ERR;
  logic [31:0] REQ0_RDATA, REQ1_RDATA;
  logic [31:0] AWADDR, WDATA, ARADDR, RDATA;
  logic        AWVALID, AWREADY, WVALID, WREADY, BVALID, BREADY;
  logic        ARVALID, ARREADY, RVALID, RREADY;
  logic [3:0]  AWCACHE, ARCACHE, WSTRB;
  logic [2:0]  AWPROT, ARPROT;
  logic [1:0]  BRESP, RRESP;

  aq_axils_arb2 #(.TIMEOUT_CYC(8)) dut (
    .ACLK(ACLK), .ARESETN(ARESETN),
    .REQ0_CS(REQ0_CS), .REQ0_RNW(REQ0_RNW), .REQ0_ADDR(REQ0_ADDR),
    .REQ0_BE(REQ0_BE), .REQ0_WDATA(REQ0_WDATA), .REQ0_ACK(REQ0_ACK),
    .REQ0_RDATA(REQ0_RDATA), .REQ0_ERR(REQ0_ERR),
    .REQ1_CS(REQ1_CS), .REQ1_RNW(REQ1_RNW), .REQ1_ADDR(REQ1_ADDR),
    .REQ1_BE(REQ1_BE), .REQ1_WDATA(REQ1_WDATA), .REQ1_ACK(REQ1_ACK),
    .REQ1_RDATA(REQ1_RDATA), .REQ1_ERR(REQ1_ERR),
    .M_AXI_AWADDR(AWADDR), .M_AXI_AWVALID(AWVALID), .M_AXI_AWREADY(AWREADY),
    .M_AXI_AWCACHE(AWCACHE), .M_AXI_AWPROT(AWPROT),
    .M_AXI_WDATA(WDATA), .M_AXI_WSTRB(WSTRB), .M_AXI_WVALID(WVALID),
    .M_AXI_WREADY(WREADY),
    .M_AXI_BVALID(BVALID), .M_AXI_BRESP(BRESP), .M_AXI_BREADY(BREADY),
    .M_AXI_ARADDR(ARADDR), .M_AXI_ARVALID(ARVALID), .M_AXI_ARREADY(ARREADY),
    .M_AXI_ARCACHE(ARCACHE), .M_AXI_ARPROT(ARPROT),
    .M_AXI_RDATA(RDATA), .M_AXI_RRESP(RRESP), .M_AXI_RVALID(RVALID),
    .M_AXI_RREADY(RREADY)
  );

  initial ACLK = 1'b0;
  always #5 ACLK = ~ACLK;

  // ---------------- slave model ----------------
  int          aw_dly = 1, w_dly = 1;
  logic [1:0]  bresp_cfg = 2'b00, rresp_cfg = 2'b00;
  logic        r_never = 1'b0;
  logic [31:0] sreg [4];
  int          aw_cnt, w_cnt;
  logic        aw_got, w_got, s_bvalid, s_rvalid;
  logic [1:0]  aw_idx;
  logic [31:0] w_dat, s_rdata, s_wdat;
  logic [3:0]  w_stb, s_wstb;
  logic [1:0]  s_widx;
  logic        s_aw_hs, s_w_hs, s_ar_hs;

  assign AWREADY = AWVALID && (aw_cnt >= aw_dly - 1);
  assign WREADY  = WVALID && (w_cnt >= w_dly - 1);
  assign ARREADY = ARVALID;
  assign s_aw_hs = AWVALID && AWREADY;
  assign s_w_hs  = WVALID && WREADY;
  assign s_ar_hs = ARVALID && ARREADY;
  assign s_widx  = s_aw_hs ? AWADDR[3:2] : aw_idx;
  assign s_wdat  = s_w_hs ? WDATA : w_dat;
  assign s_wstb  = s_w_hs ? WSTRB : w_stb;
  assign BVALID  = s_bvalid;
  assign BRESP   = s_bvalid ? bresp_cfg : 2'b00;
  assign RVALID  = s_rvalid;
  assign RRESP   = s_rvalid ? rresp_cfg : 2'b00;
  assign RDATA   = s_rdata;

  always @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      for (int i = 0; i < 4; i++) sreg[i] <= '0;
      aw_cnt <= 0; w_cnt <= 0; aw_got <= 1'b0; w_got <= 1'b0;
      aw_idx <= '0; w_dat <= '0; w_stb <= '0;
      s_bvalid <= 1'b0; s_rvalid <= 1'b0; s_rdata <= '0;
    end else begin
      aw_cnt <= (AWVALID && !AWREADY) ? aw_cnt + 1 : 0;
      w_cnt  <= (WVALID && !WREADY) ? w_cnt + 1 : 0;
      if (s_aw_hs) begin aw_got <= 1'b1; aw_idx <= AWADDR[3:2]; end
      if (s_w_hs) begin w_got <= 1'b1; w_dat <= WDATA; w_stb <= WSTRB; end
      if ((aw_got || s_aw_hs) && (w_got || s_w_hs)) begin
        for (int b = 0; b < 4; b++)
          if (s_wstb[b]) sreg[s_widx][8*b +: 8] <= s_wdat[8*b +: 8];
        aw_got <= 1'b0; w_got <= 1'b0; s_bvalid <= 1'b1;
      end
      if (s_bvalid && BREADY) s_bvalid <= 1'b0;
      if (s_ar_hs && !r_never) begin
        s_rvalid <= 1'b1; s_rdata <= sreg[ARADDR[3:2]];
      end
      if (s_rvalid && RREADY) s_rvalid <= 1'b0;
    end
  end

  // ---------------- scoreboard ----------------
  typedef struct {
    int          port;
    logic [31:0] rdata;
    logic        err;
    int          cyc;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] aw_q[$];
  logic [35:0] w_q[$];
  logic [31:0] ar_q[$];
  int tests = 0, fails = 0, cyc = 0;
  int aw_vcyc = 0, w_vcyc = 0, b_hs = 0, n_ack = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] expv);
    tests++;
    if (act !== expv) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", nm, act, expv, cyc);
    end
  endtask

  task automatic expect_ack(input int p, input logic [31:0] rd, input logic e, input int lat);
    exp_t x;
    x.port = p; x.rdata = rd; x.err = e; x.cyc = cyc + lat;
    exp_q.push_back(x);
  endtask

  task automatic monitor();
    exp_t e;
    int   p;
    forever begin
      @(negedge ACLK);
      if (AWVALID) aw_vcyc++;
      if (WVALID) w_vcyc++;
      if (BVALID && BREADY) b_hs++;
      if (REQ0_ACK || REQ1_ACK) begin
        n_ack++;
        chk("ack_exclusive", {63'd0, REQ0_ACK & REQ1_ACK}, 64'd0);
        p = REQ1_ACK ? 1 : 0;
        if (exp_q.size() == 0) chk("unexpected_ack", 64'(p), 64'hFFFF);
        else begin
          e = exp_q.pop_front();
          chk("ack_port", 64'(p), 64'(e.port));
          chk("ack_rdata", p ? REQ1_RDATA : REQ0_RDATA, e.rdata);
          chk("ack_err", p ? REQ1_ERR : REQ0_ERR, e.err);
          chk("ack_cycle", 64'(cyc), 64'(e.cyc));
          chk("other_rdata_zero", p ? REQ0_RDATA : REQ1_RDATA, 64'd0);
        end
      end
      if (AWVALID && AWREADY) begin
        if (aw_q.size() == 0) chk("unexpected_aw", AWADDR, 64'hFFFF_FFFF_FFFF);
        else chk("awaddr", AWADDR, aw_q.pop_front());
      end
      if (WVALID && WREADY) begin
        if (w_q.size() == 0) chk("unexpected_w", WDATA, 64'hFFFF_FFFF_FFFF);
        else chk("wstrb_wdata", {WSTRB, WDATA}, w_q.pop_front());
      end
      if (ARVALID && ARREADY) begin
        if (ar_q.size() == 0) chk("unexpected_ar", ARADDR, 64'hFFFF_FFFF_FFFF);
        else chk("araddr", ARADDR, ar_q.pop_front());
      end
    end
  endtask

  // Drives one request starting at the current negedge, waits for its ACK.
  task automatic do_req(input int p, input logic rnw, input logic [31:0] addr,
                        input logic [3:0] be, input logic [31:0] wd);
    bit got;
    got = 1'b0;
    if (p == 0) begin
      REQ0_CS = 1'b1; REQ0_RNW = rnw; REQ0_ADDR = addr; REQ0_BE = be; REQ0_WDATA = wd;
    end else begin
      REQ1_CS = 1'b1; REQ1_RNW = rnw; REQ1_ADDR = addr; REQ1_BE = be; REQ1_WDATA = wd;
    end
    for (int i = 0; i < 100 && !got; i++) begin
      @(negedge ACLK);
      got = (p == 0) ? REQ0_ACK : REQ1_ACK;
    end
    chk(p == 0 ? "req0_completed" : "req1_completed", {63'd0, got}, 64'd1);
    if (p == 0) REQ0_CS = 1'b0; else REQ1_CS = 1'b0;
  endtask

  initial begin
    int  a0, w0, b0, n0;
    bit  seen;
    ARESETN = 1'b0;
    REQ0_CS = 1'b0; REQ0_RNW = 1'b0; REQ0_ADDR = '0; REQ0_BE = '0; REQ0_WDATA = '0;
    REQ1_CS = 1'b0; REQ1_RNW = 1'b0; REQ1_ADDR = '0; REQ1_BE = '0; REQ1_WDATA = '0;
    fork
      forever begin @(posedge ACLK); cyc++; end
      monitor();
    join_none

    // reset values
    repeat (3) @(negedge ACLK);
    chk("rst_valids", {AWVALID, WVALID, BREADY, ARVALID, RREADY}, 64'd0);
    chk("rst_acks", {REQ0_ACK, REQ1_ACK, REQ0_ERR, REQ1_ERR}, 64'd0);
    chk("rst_rdata", {REQ0_RDATA, REQ1_RDATA}, 64'd0);
    chk("rst_addr_data", {AWADDR, WDATA}, 64'd0);
    chk("axi_cache_prot", {AWCACHE, AWPROT, ARCACHE, ARPROT}, {50'd0, 4'b0011, 3'b000, 4'b0011, 3'b000});
    ARESETN = 1'b1;

    // single write, then read-back from requester 1
    @(negedge ACLK);
    aw_q.push_back(32'h04); w_q.push_back({4'hF, 32'hDEADBEEF});
    expect_ack(0, 32'h0, 1'b0, 3);
    do_req(0, 1'b0, 32'h04, 4'hF, 32'hDEADBEEF);
    @(negedge ACLK);
    ar_q.push_back(32'h04);
    expect_ack(1, 32'hDEADBEEF, 1'b0, 3);
    do_req(1, 1'b1, 32'h04, 4'h0, 32'h0);

    // tie: requester 0 first (last grant was 1)
    @(negedge ACLK);
    aw_q.push_back(32'h08); w_q.push_back({4'hF, 32'h11223344}); ar_q.push_back(32'h08);
    expect_ack(0, 32'h0, 1'b0, 3);
    expect_ack(1, 32'h11223344, 1'b0, 7);
    fork
      do_req(0, 1'b0, 32'h08, 4'hF, 32'h11223344);
      do_req(1, 1'b1, 32'h08, 4'h0, 32'h0);
    join

    // lone requester 0, so the next tie goes to requester 1
    @(negedge ACLK);
    ar_q.push_back(32'h04);
    expect_ack(0, 32'hDEADBEEF, 1'b0, 3);
    do_req(0, 1'b1, 32'h04, 4'h0, 32'h0);
    @(negedge ACLK);
    aw_q.push_back(32'h0C); w_q.push_back({4'hC, 32'hA5A5A5A5}); ar_q.push_back(32'h0C);
    expect_ack(1, 32'h0, 1'b0, 3);
    expect_ack(0, 32'hA5A50000, 1'b0, 7);
    fork
      do_req(0, 1'b1, 32'h0C, 4'h0, 32'h0);
      do_req(1, 1'b0, 32'h0C, 4'hC, 32'hA5A5A5A5);
    join

    // split handshake: AWREADY after 3 cycles, WREADY after 1
    @(negedge ACLK);
    aw_dly = 3; w_dly = 1;
    a0 = aw_vcyc; w0 = w_vcyc; b0 = b_hs; n0 = n_ack;
    aw_q.push_back(32'h00); w_q.push_back({4'hF, 32'h12345678});
    expect_ack(0, 32'h0, 1'b0, 5);
    do_req(0, 1'b0, 32'h00, 4'hF, 32'h12345678);
    @(negedge ACLK);
    chk("split_awvalid_cycles", 64'(aw_vcyc - a0), 64'd3);
    chk("split_wvalid_cycles", 64'(w_vcyc - w0), 64'd1);
    chk("split_b_handshakes", 64'(b_hs - b0), 64'd1);
    chk("split_ack_count", 64'(n_ack - n0), 64'd1);
    aw_dly = 1;

    // slave error responses
    bresp_cfg = 2'b10;
    aw_q.push_back(32'h08); w_q.push_back({4'hF, 32'hCAFEF00D});
    expect_ack(1, 32'h0, 1'b1, 3);
    do_req(1, 1'b0, 32'h08, 4'hF, 32'hCAFEF00D);
    @(negedge ACLK);
    bresp_cfg = 2'b00; rresp_cfg = 2'b10;
    ar_q.push_back(32'h04);
    expect_ack(1, 32'hDEADBEEF, 1'b1, 3);
    do_req(1, 1'b1, 32'h04, 4'h0, 32'h0);
    @(negedge ACLK);
    rresp_cfg = 2'b00;

    // timeout on a read whose RVALID never comes
    r_never = 1'b1;
    ar_q.push_back(32'h04);
    expect_ack(0, 32'h0, 1'b1, 11);
    do_req(0, 1'b1, 32'h04, 4'h0, 32'h0);
    chk("timeout_rready_dropped", {63'd0, RREADY}, 64'd0);

    // reset while waiting in the read-data phase
    @(negedge ACLK);
    ar_q.push_back(32'h08);
    REQ0_CS = 1'b1; REQ0_RNW = 1'b1; REQ0_ADDR = 32'h08;
    seen = 1'b0;
    for (int i = 0; i < 5 && !seen; i++) begin
      @(negedge ACLK);
      seen = RREADY;
    end
    chk("mid_read_reached_rdata", {63'd0, seen}, 64'd1);
    ARESETN = 1'b0;
    #1;
    chk("mid_reset_rready", {63'd0, RREADY}, 64'd0);
    chk("mid_reset_ack_err", {REQ0_ACK, REQ1_ACK, REQ0_ERR}, 64'd0);
    chk("mid_reset_arvalid", {63'd0, ARVALID}, 64'd0);
    REQ0_CS = 1'b0;
    repeat (2) @(negedge ACLK);
    ARESETN = 1'b1;
    r_never = 1'b0;

    @(negedge ACLK);
    aw_q.push_back(32'h00); w_q.push_back({4'hF, 32'h0BADF00D});
    expect_ack(1, 32'h0, 1'b0, 3);
    do_req(1, 1'b0, 32'h00, 4'hF, 32'h0BADF00D);
    @(negedge ACLK);
    ar_q.push_back(32'h00);
    expect_ack(0, 32'h0BADF00D, 1'b0, 3);
    do_req(0, 1'b1, 32'h00, 4'h0, 32'h0);

    repeat (3) @(negedge ACLK);
    chk("ack_queue_drained", 64'(exp_q.size()), 64'd0);
    chk("chan_queues_drained", 64'(aw_q.size() + w_q.size() + ar_q.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/aq_axils_arb2.md
# aq_axils_arb2

Two-requester AXI4-Lite master arbiter. It accepts single-beat register accesses from two local requesters over a simple cs/ack local bus and issues each one as an AXI4-Lite transaction on one shared master port. Arbitration is round-robin. The block drives the shared AXI4-Lite register slaves in the design, such as the sample 4-register slave. It sequences each access through address, data and response phases and returns the read data and response status to the requester that was granted.

## Interface
- TIMEOUT_CYC, 1023: cycles to wait in any AXI phase before aborting; 0 disables the timeout.
- ACLK  in  1  clock.
- ARESETN  in  1  reset, asynchronous, active-low.
- REQn_CS  in  1  access request from requester n (n = 0, 1); held high until REQn_ACK.
- REQn_RNW  in  1  1 = read, 0 = write; stable while CS is high.
- REQn_ADDR  in  32  byte address; stable while CS is high.
- REQn_BE  in  4  write byte enables, driven onto WSTRB.
- REQn_WDATA  in  32  write data.
- REQn_ACK  out  1  one-cycle completion pulse.
- REQn_RDATA  out  32  read data; valid while ACK is high, 0 otherwise.
- REQn_ERR  out  1  valid with ACK; 1 if the response was nonzero or the access timed out.
- M_AXI_AWADDR/AWVALID  out  32/1; M_AXI_AWREADY  in  1.
- M_AXI_AWCACHE  out  4  constant 4'b0011.
- M_AXI_AWPROT  out  3  constant 3'b000.
- M_AXI_WDATA/WSTRB/WVALID  out  32/4/1; M_AXI_WREADY  in  1.
- M_AXI_BVALID  in  1; M_AXI_BRESP  in  2; M_AXI_BREADY  out  1.
- M_AXI_ARADDR/ARVALID  out  32/1; M_AXI_ARREADY  in  1.
- M_AXI_ARCACHE  out  4  constant 4'b0011.
- M_AXI_ARPROT  out  3  constant 3'b000.
- M_AXI_RDATA  in  32; M_AXI_RRESP  in  2; M_AXI_RVALID  in  1; M_AXI_RREADY  out  1.

## Operation
- FSM states: IDLE, WADDR, WRESP, RADDR, RDATA, DONE.
- **IDLE:**
  - If any REQn_CS is high, grant a requester. Capture its rnw, addr, be and wdata into registers, and record the grant.
  - Go to WADDR for a write or RADDR for a read.
- **Arbitration:**
  - One request pending: grant it.
  - Both pending: grant the requester not granted last.
  - The last-grant register resets to 1, so requester 0 wins the first tie.
- **WADDR:**
  - AWVALID and WVALID assert together.
  - Each drops independently on its own handshake (AWVALID&AWREADY, WVALID&WREADY); per-channel done flags track this.
  - When both channels are done, go to WRESP.
- **WRESP:** BREADY=1. On BVALID, latch err=(BRESP!=0) and go to DONE.
- **RADDR:** ARVALID=1. On ARREADY, go to RDATA.
- **RDATA:** RREADY=1. On RVALID, latch RDATA and err=(RRESP!=0), then go to DONE.
- **DONE:**
  - The granted REQn_ACK is high for exactly this cycle, with RDATA (read only, else 0) and ERR.
  - Next state is IDLE.
- Only one transaction is outstanding at a time; there is no pipelining.
- **Timeout:**
  - A counter clears on every state change and increments in WADDR, WRESP, RADDR and RDATA.
  - On reaching TIMEOUT_CYC (when nonzero): drop all VALID/READY outputs and go to DONE with ERR=1 and RDATA=0. This is a debug escape only and is non-AXI-compliant.
- A requester must deassert CS in the cycle after its ACK; otherwise IDLE treats it as a new request.

## Timing
- **Reset values:**
  - All VALID/READY outputs, REQn_ACK, REQn_ERR, REQn_RDATA: 0.
  - AXI address and data outputs: 0.
  - State: IDLE. Last grant: 1. Timeout counter: 0.
- All outputs are registered or decoded from the state register; there are no combinational paths from inputs to outputs.
- **Zero-wait slave write:** CS at cycle 0 → WADDR cycle 1 → WRESP cycle 2 (BVALID same cycle) → ACK at cycle 3.
- **Zero-wait slave read:** CS at cycle 0 → RADDR cycle 1 → RDATA cycle 2 → ACK at cycle 3.
- **Back-to-back:** the minimum gap from one ACK to the next grant's first AXI valid is 2 cycles (DONE→IDLE→phase).
- **Reset mid-transaction:** all outputs return to reset values immediately and no ACK is issued. The requester re-issues after reset.
- CS changes while not granted are ignored until IDLE.

## Test plan
- **Single write:** REQ0 write 0x04 ← 0xDEADBEEF, BE=0xF, zero-wait slave → AWADDR=0x04, WDATA=0xDEADBEEF, WSTRB=0xF; ACK0 at cycle 3, ERR0=0; slave REG1 reads back 0xDEADBEEF.
- **Read:** REQ1 read 0x04 → ARADDR=0x04; ACK1 with RDATA1=0xDEADBEEF, ERR1=0; RDATA0 stays 0.
- **Simultaneous requests:** CS0 and CS1 high at the same cycle out of reset → REQ0 served first, then REQ1. Repeating the tie alternates the grant 1,0,1.
- **Split handshake:** AWREADY delayed 3 cycles and WREADY delayed 1 cycle → WVALID drops after 1 cycle, AWVALID after 3 cycles; exactly one BREADY phase; ACK once.
- **Error and timeout:**
  - BRESP=2'b10 → ERR=1.
  - With TIMEOUT_CYC=8 and RVALID never asserted → RREADY drops, ACK arrives with ERR=1 and RDATA=0.
- **Reset mid-read:** ARESETN low while in RDATA → RREADY=0 and ACK=0 immediately; after release, the next request completes normally.
